// File: rtl/core_bus_requester.sv
// Per-core bus master front end: turns a core read/write burst command into an arbiter request/grant
// handshake plus a strobe/ack transfer, holding request for the burst then dropping it for a gap.
// Latency: accept->REQ 1, REQ->XFER 1, one beat per acked cycle, RELEASE_CYCLES gap, then oCoreDone.
// Backpressure: grant loss stalls the strobe (beat count frozen); missing ack holds the strobe and current beat.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   core_req_i/core_we_i/core_addr_i/burst_len_i : burst command, sampled only in IDLE
//   core_wr_data_i / core_wr_pop_o               : write word source, pop pulses on each accepted write beat
//   core_rd_data_o / core_rd_valid_o             : registered read word with 1-cycle valid pulse
//   core_busy_o, core_done_o, core_error_o       : command status
//   request_o / grant_i                          : arbiter handshake
//   bus_addr_o, bus_data_o, bus_we_o, bus_stb_o  : shared bus drive (zero outside XFER)
//   bus_data_i, bus_ack_i                        : bus read data and beat acknowledge
// Optional feature: define BUS_REQ_TIMEOUT_EN to enable the REQ/XFER watchdog (abort -> done+error).
module core_bus_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 4,
    parameter int RELEASE_CYCLES = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    input  logic [DATA_W-1:0] core_wr_data_i,
    output logic              core_wr_pop_o,
    output logic [DATA_W-1:0] core_rd_data_o,
    output logic              core_rd_valid_o,
    output logic              core_busy_o,
    output logic              core_done_o,
    output logic              core_error_o,
    output logic              request_o,
    input  logic              grant_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_we_o,
    output logic              bus_stb_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    // One extra bit so a 16-beat burst counts to 16 without wrapping.
    logic [LEN_W:0]      beat_q, beat_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;

    logic                in_xfer;
    logic                beat_ack;
    logic                last_beat;
    logic                timeout_hit;
    logic                release_exit;

    assign in_xfer      = (state_q == ST_XFER);
    // Strobe follows grant so a lost grant stalls the burst rather than aborting it.
    assign bus_stb_o    = in_xfer & grant_i;
    assign beat_ack     = bus_stb_o & bus_ack_i;
    assign last_beat    = (beat_q == {1'b0, len_q});
    assign release_exit = (state_q == ST_RELEASE) && (rel_q == REL_W'(RELEASE_CYCLES - 1));

    assign request_o     = (state_q == ST_REQ) || in_xfer;
    assign core_busy_o   = (state_q != ST_IDLE);
    assign core_wr_pop_o = beat_ack & we_q;
    // Bus drive is gated to XFER so the shared bus sees zeros in every other state, including reset.
    assign bus_addr_o    = in_xfer ? (base_q + ADDR_W'(beat_q)) : '0;
    assign bus_data_o    = in_xfer ? core_wr_data_i : '0;
    assign bus_we_o      = in_xfer & we_q;

    assign core_rd_data_o  = rd_data_q;
    assign core_rd_valid_o = rd_valid_q;
    assign core_done_o     = done_q;

`ifdef BUS_REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            abort_q, abort_d;
    logic            error_q;
    logic            progress;

    // Any forward step (grant in REQ, or an acked beat) restarts the watchdog.
    assign progress    = ((state_q == ST_REQ) && grant_i) || beat_ack;
    assign timeout_hit = ((state_q == ST_REQ) || in_xfer) && !progress &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        abort_d  = abort_q;
        if (((state_q == ST_REQ) || in_xfer) && !progress && !timeout_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            abort_d = 1'b1;
        end else if (release_exit) begin
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            abort_q  <= abort_d;
            error_q  <= release_exit & abort_q;
        end
    end

    assign core_error_o = error_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign core_error_o       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rel_d      = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The cycle carrying done is still closing the previous burst; no accept there.
                if (core_req_i && !done_q) begin
                    we_d    = core_we_i;
                    base_d  = core_addr_i;
                    len_d   = burst_len_i;
                    beat_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (timeout_hit) begin
                    state_d = ST_RELEASE;
                end else if (grant_i) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (!we_q) begin
                        rd_data_d  = bus_data_i;
                        rd_valid_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_RELEASE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (release_exit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            rel_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            base_q     <= base_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            rel_q      <= rel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

endmodule
